// File: rtl/lcd_text_renderer.sv
// Text-mode pixel generator: walks the character buffer, fetches font rows, serialises pixels.
// Optional reverse-video attribute on code bit 7 when ATTR_INVERT_EN is defined.
module lcd_text_renderer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 15,
  parameter int TXT_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [7:0]        txt_data,
  output logic [31:0]       font_addr,
  input  logic [7:0]        font_data,
  output logic              pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
);

  typedef enum logic [2:0] {IDLE, REQ_T, CAP_T, REQ_F, CAP_F, SHIFT} state_t;

  localparam logic [TXT_AW-1:0] COL_LAST = TXT_AW'(COLS - 1);
  localparam logic [TXT_AW-1:0] ROW_LAST = TXT_AW'(ROWS - 1);
  localparam logic [TXT_AW-1:0] COLS_W   = TXT_AW'(COLS);

  state_t            state;
  logic [TXT_AW-1:0] col, row, base;
  logic [3:0]        frow;
  logic [2:0]        bitcnt;
  logic [7:0]        code_q, shreg, load_byte;
  logic [TXT_AW-1:0] nxt_col, nxt_row, nxt_base;
  logic [3:0]        nxt_frow;
  logic              last_cell, accept;

`ifdef ATTR_INVERT_EN
  assign load_byte = code_q[7] ? ~font_data : font_data;
`else
  logic unused_attr;
  assign unused_attr = code_q[7];
  assign load_byte   = font_data;
`endif

  assign accept    = pix_valid && pix_ready;
  assign last_cell = (row == ROW_LAST) && (frow == 4'hF) && (col == COL_LAST);
  assign pix_data  = pix_valid & shreg[7];
  assign pix_sof   = pix_valid && (bitcnt == 3'd0) && (row == '0) && (frow == 4'd0) && (col == '0);
  assign pix_eol   = pix_valid && (bitcnt == 3'd7) && (col == COL_LAST);

  // base tracks row*COLS so the next text address needs only an add
  always_comb begin
    nxt_col  = col + TXT_AW'(1);
    nxt_frow = frow;
    nxt_row  = row;
    nxt_base = base;
    if (col == COL_LAST) begin
      nxt_col  = '0;
      nxt_frow = frow + 4'd1;
      if (frow == 4'hF) begin
        nxt_row  = row + TXT_AW'(1);
        nxt_base = base + COLS_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      txt_addr  <= '0;
      font_addr <= '0;
      pix_valid <= 1'b0;
      col       <= '0;
      row       <= '0;
      base      <= '0;
      frow      <= '0;
      bitcnt    <= '0;
      code_q    <= '0;
      shreg     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ_T;
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            base     <= '0;
            frow     <= '0;
            txt_addr <= '0;
          end
        end
        REQ_T: state <= CAP_T;
        // font address is launched from the captured code so REQ_F sees it immediately
        CAP_T: begin
          code_q    <= txt_data;
          font_addr <= {21'b0, txt_data[6:0], frow};
          state     <= REQ_F;
        end
        REQ_F: state <= CAP_F;
        CAP_F: begin
          shreg     <= load_byte;
          bitcnt    <= '0;
          pix_valid <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (accept) begin
            shreg  <= {shreg[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              pix_valid <= 1'b0;
              if (last_cell) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                col      <= nxt_col;
                frow     <= nxt_frow;
                row      <= nxt_row;
                base     <= nxt_base;
                txt_addr <= nxt_base + nxt_col;
                state    <= REQ_T;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_renderer.sv
// Self-checking bench for lcd_text_renderer: random text/font/backpressure against a frame-level model.
// Honours ATTR_INVERT_EN the same way the design does.
module tb_lcd_text_renderer;

  localparam int COLS   = 2;
  localparam int ROWS   = 2;
  localparam int TXT_AW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [TXT_AW-1:0] txt_addr;
  logic [7:0]        txt_data;
  logic [31:0]       font_addr;
  logic [7:0]        font_data;
  logic              pix_data, pix_valid, pix_sof, pix_eol;
  logic              pix_ready;

  lcd_text_renderer #(.COLS(COLS), .ROWS(ROWS), .TXT_AW(TXT_AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .txt_addr(txt_addr), .txt_data(txt_data), .font_addr(font_addr), .font_data(font_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  always #5 clk = ~clk;

  logic [7:0] txt_mem [16];
  logic [7:0] rom [2048];

  always @(posedge clk) begin
    txt_data  <= txt_mem[txt_addr];
    font_data <= rom[font_addr[10:0]];
  end

  typedef struct {
    logic        d;
    logic        sof;
    logic        eol;
    logic [3:0]  ta;
    logic [31:0] fa;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_acc = 0;
  int   ready_mode = 0;
  int   stall_left = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pixel stream of one frame, built straight from the raster-order rules
  function automatic void loadFrame();
    for (int r = 0; r < ROWS; r++)
      for (int f = 0; f < 16; f++)
        for (int c = 0; c < COLS; c++) begin
          logic [7:0] code, b;
          pix_t p;
          code = txt_mem[r*COLS + c];
          b    = rom[{code[6:0], 4'(f)}];
`ifdef ATTR_INVERT_EN
          if (code[7]) b = ~b;
`endif
          for (int i = 7; i >= 0; i--) begin
            p.d   = b[i];
            p.sof = (r == 0) && (f == 0) && (c == 0) && (i == 7);
            p.eol = (i == 0) && (c == COLS - 1);
            p.ta  = 4'(r*COLS + c);
            p.fa  = {21'b0, code[6:0], 4'(f)};
            exp_q.push_back(p);
          end
        end
  endfunction

  // Backpressure source, updated just after each rising edge
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (frame_acc == 3 && pix_valid && stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
          end else pix_ready = 1'b1;
        end
      endcase
    end
  end

  // Pixel monitor: every accepted pixel must match the model; stalled outputs must hold
  logic       prev_stall = 1'b0;
  logic [2:0] prev_out = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(pix_valid), 64'd1);
        checkOutput("hold_pixel", 64'({pix_data, pix_sof, pix_eol}), 64'(prev_out));
      end
      if (pix_valid && pix_ready) begin
        checkOutput("pixel_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          pix_t e;
          e = exp_q.pop_front();
          checkOutput("pixel", 64'({pix_data, pix_sof, pix_eol, txt_addr, font_addr}),
                      64'({e.d, e.sof, e.eol, e.ta, e.fa}));
        end
        frame_acc++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_out   = {pix_data, pix_sof, pix_eol};
    end
  end

  // Caller raises start; this runs the frame to done and checks its length and handshake
  task automatic applyStimulus(input int expect_cycles, input bit poke_busy);
    int n;
    n = 0;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    while (!done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (poke_busy && n == 100) start = 1'b1;
      if (poke_busy && n == 101) start = 1'b0;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
    if (expect_cycles > 0) checkOutput("frame_cycles", 64'(n), 64'(expect_cycles));
    checkOutput("busy_at_done", 64'(busy), 64'd0);
    checkOutput("all_pixels_out", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int  n;
    logic act;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h410] = 8'hA5;
    txt_mem[0] = 8'h41;
    txt_mem[1] = 8'h20;
    txt_mem[2] = 8'hC1;
    for (int i = 3; i < 16; i++) txt_mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 64'({busy, done, pix_valid, pix_data, pix_sof, pix_eol, txt_addr, font_addr}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", 64'({busy, pix_valid}), 64'd0);

    $display("[TB] frame 1: ready tied high, start pulsed while busy");
    loadFrame();
    start = 1'b1;
    applyStimulus(12*COLS*ROWS*16, 1'b1);

    $display("[TB] frame 2: started in done cycle, 5-cycle stall at pixel 3");
    frame_acc  = 0;
    stall_left = 5;
    ready_mode = 2;
    loadFrame();
    start = 1'b1;
    applyStimulus(12*COLS*ROWS*16 + 5, 1'b0);

    $display("[TB] frame 3: random text and random backpressure");
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) txt_mem[i] = 8'($urandom);
    ready_mode = 1;
    loadFrame();
    start = 1'b1;
    applyStimulus(0, 1'b0);

    $display("[TB] frame 4: reset asserted mid-shift");
    @(posedge clk);
    #1;
    loadFrame();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!pix_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("valid_before_abort", 64'(pix_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", 64'({busy, done, pix_valid, pix_data, pix_sof, pix_eol, txt_addr, font_addr}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    act = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      act = act | busy | done | pix_valid;
    end
    checkOutput("quiet_after_abort", 64'(act), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
